// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and
// width helpers used by uart_tx_arbiter and uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART bundle around uart_tx_arbiter; master is the requester and
// uart side, slave is the arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2w(N_REQ)
);
  // valid/ready: a byte moves on any cycle where req_valid[i] && req_ready[i];
  // a requester keeps valid, data and last steady until that cycle.
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_data;
  logic [N_REQ-1:0]      req_last;
  logic [N_REQ-1:0]      req_ready;
  logic                  uart_busy;
  logic                  uart_write;
  logic [7:0]            uart_data;
  logic [IW-1:0]         grant_id;
  logic                  active;

  modport master (
    output req_valid, req_data, req_last, uart_busy,
    input  req_ready, uart_write, uart_data, grant_id, active
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_busy,
    output req_ready, uart_write, uart_data, grant_id, active
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int j;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_REQ;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between N_REQ byte
// streams; the uart_tx itself is connected beside this block by the parent.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int IW           = clog2w(N_REQ),
  parameter int CW           = clog2w(HOLD_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][7:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  uart_busy,
  output logic                  uart_write,
  output logic [7:0]            uart_data,
  output logic [IW-1:0]         grant_id,
  output logic                  active,
  output arb_state_e            state_dbg
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          accept;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] next_ptr;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign next_ptr = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (req_valid[grant_q]) begin
          cnt_d = '0;
          if (!uart_busy) begin
            accept  = 1'b1;
            last_d  = req_last[grant_q];
            state_d = WAIT_START;
          end
        end else if (cnt_q == CW'(HOLD_TIMEOUT - 1)) begin
          // Owner went quiet mid-packet: give the line to the next requester.
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // uart_tx only raises busy the cycle after the write strobe.
      WAIT_START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!uart_busy) begin
          if (last_q) begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_q] = 1'b1;
  end

  assign uart_write = accept;
  assign uart_data  = accept ? req_data[grant_q] : 8'h00;
  assign grant_id   = grant_q;
  assign active     = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with byte-queue requesters, a busy model
// of uart_tx and an in-order scoreboard of {grant_id, data} writes.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int BUSY_LEN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  arb_state_e state_dbg;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (bus.req_valid),
    .req_data   (bus.req_data),
    .req_last   (bus.req_last),
    .req_ready  (bus.req_ready),
    .uart_busy  (bus.uart_busy),
    .uart_write (bus.uart_write),
    .uart_data  (bus.uart_data),
    .grant_id   (bus.grant_id),
    .active     (bus.active),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_writes = 0;

  logic [11:0] exp_q[$];
  logic [8:0]  src_mem [N][16];
  int          src_head [N];
  int          src_tail [N];
  logic        prev_w = 1'b0;
  logic        wr_seen = 1'b0;
  logic [N-1:0] acc_seen = '0;
  int          busy_cnt = 0;

  // Requester queues and uart_tx busy model, updated just after each rising edge.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.uart_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (wr_seen) busy_cnt = BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt--;
        for (int i = 0; i < N; i++)
          if (acc_seen[i]) src_head[i]++;
      end
      bus.uart_busy = (busy_cnt > 0);
      for (int i = 0; i < N; i++) begin
        if (src_head[i] < src_tail[i]) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i]  = src_mem[i][src_head[i]][7:0];
          bus.req_last[i]  = src_mem[i][src_head[i]][8];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_data[i]  = 8'h00;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard and write-protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic [11:0]  e;
    if (rst) begin
      prev_w   = 1'b0;
      wr_seen  = 1'b0;
      acc_seen = '0;
    end else begin
      n_total++;
      if (bus.uart_write && (bus.uart_busy || prev_w))
        $display("FAIL write_protocol: write=%b busy=%b prev_write=%b, required no write", bus.uart_write, bus.uart_busy, prev_w);
      else n_pass++;
      exp_ready = bus.uart_write ? (N'(1) << bus.grant_id) : '0;
      n_total++;
      if (bus.req_ready !== exp_ready)
        $display("FAIL ready_onehot: req_ready=%b required %b", bus.req_ready, exp_ready);
      else n_pass++;
      if (bus.uart_write) begin
        n_writes++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: id=%0d data=%h, required no write", bus.grant_id, bus.uart_data);
        end else begin
          e = exp_q.pop_front();
          if ({4'(bus.grant_id), bus.uart_data} !== e)
            $display("FAIL write_order: id/data=%h required %h", {4'(bus.grant_id), bus.uart_data}, e);
          else n_pass++;
        end
      end
      prev_w   = bus.uart_write;
      wr_seen  = bus.uart_write;
      acc_seen = bus.req_ready;
    end
  end

  task automatic push_byte(input int id, input logic [7:0] d, input logic l);
    src_mem[id][src_tail[id]] = {l, d};
    src_tail[id]++;
  endtask

  task automatic expect_write(input int id, input logic [7:0] d);
    exp_q.push_back({4'(id), d});
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
  endtask

  function automatic bit drained();
    drained = 1'b1;
    for (int i = 0; i < N; i++)
      if (src_head[i] < src_tail[i]) drained = 1'b0;
  endfunction

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!bus.active && exp_q.size() == 0 && drained()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.uart_write, bus.uart_data, bus.req_ready, bus.active} !== 14'h0)
      $display("FAIL reset_outputs: write/data/ready/active=%h required 0", {bus.uart_write, bus.uart_data, bus.req_ready, bus.active});
    else n_pass++;
    n_total++;
    if (bus.grant_id !== 2'd0) $display("FAIL reset_grant: grant_id=%0d required 0", bus.grant_id);
    else n_pass++;
    n_total++;
    if (state_dbg !== IDLE) $display("FAIL reset_state: state=%0d required %0d", state_dbg, IDLE);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention();
    bit ok;
    clear_queues();
    push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b0); push_byte(0, 8'hA2, 1'b1);
    push_byte(2, 8'hC0, 1'b0); push_byte(2, 8'hC1, 1'b1);
    expect_write(0, 8'hA0); expect_write(0, 8'hA1); expect_write(0, 8'hA2);
    expect_write(2, 8'hC0); expect_write(2, 8'hC1);
    wait_quiet(ok);
    n_total++;
    if (!ok) $display("FAIL contention_done: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
    n_total++;
    if (bus.grant_id !== 2'd2) $display("FAIL contention_grant: grant_id=%0d required 2", bus.grant_id);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    clear_queues();
    push_byte(0, 8'h10, 1'b1);
    push_byte(3, 8'h30, 1'b0); push_byte(3, 8'h31, 1'b1);
    expect_write(3, 8'h30); expect_write(3, 8'h31); expect_write(0, 8'h10);
    wait_quiet(ok);
    n_total++;
    if (!ok) $display("FAIL wrap_done: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    clear_queues();
    push_byte(1, 8'h41, 1'b0); push_byte(1, 8'h42, 1'b1);
    expect_write(1, 8'h41); expect_write(1, 8'h42);
    wait_quiet(ok);
    n_total++;
    if (!ok) $display("FAIL single_done: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
    n_total++;
    if (state_dbg !== IDLE || bus.active !== 1'b0)
      $display("FAIL single_idle: state=%0d active=%b required IDLE/0", state_dbg, bus.active);
    else n_pass++;
    // Pointer now sits at 2, so requester 2 must beat requester 1.
    clear_queues();
    push_byte(1, 8'h61, 1'b1);
    push_byte(2, 8'h62, 1'b1);
    expect_write(2, 8'h62); expect_write(1, 8'h61);
    wait_quiet(ok);
    n_total++;
    if (!ok) $display("FAIL rr_ptr_after_single: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int n_send;
    clear_queues();
    push_byte(1, 8'h51, 1'b0);
    expect_write(1, 8'h51);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) $display("FAIL timeout_first_byte: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
    push_byte(2, 8'h71, 1'b1);
    expect_write(2, 8'h71);
    n_send = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (state_dbg == SEND) n_send++;
      else if (n_send > 0) break;
    end
    n_total++;
    if (n_send != 8) $display("FAIL timeout_cycles: send_cycles=%0d required 8", n_send);
    else n_pass++;
    n_total++;
    if (state_dbg !== IDLE || bus.active !== 1'b0)
      $display("FAIL timeout_release: state=%0d active=%b required IDLE/0", state_dbg, bus.active);
    else n_pass++;
    wait_quiet(ok);
    n_total++;
    if (!ok) $display("FAIL timeout_next_grant: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
    n_total++;
    if (bus.grant_id !== 2'd2) $display("FAIL timeout_grant: grant_id=%0d required 2", bus.grant_id);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int base;
    clear_queues();
    push_byte(3, 8'h81, 1'b0); push_byte(3, 8'h82, 1'b0); push_byte(3, 8'h83, 1'b1);
    expect_write(3, 8'h81);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && state_dbg == WAIT_DONE) begin ok = 1'b1; break; end
    end
    n_total++;
    if (!ok) $display("FAIL midreset_reach_wait_done: state=%0d required %0d", state_dbg, WAIT_DONE);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bus.uart_write, bus.uart_data, bus.req_ready, bus.active} !== 14'h0)
      $display("FAIL midreset_async_outputs: write/data/ready/active=%h required 0", {bus.uart_write, bus.uart_data, bus.req_ready, bus.active});
    else n_pass++;
    n_total++;
    if (bus.grant_id !== 2'd0 || state_dbg !== IDLE)
      $display("FAIL midreset_async_state: grant_id=%0d state=%0d required 0/IDLE", bus.grant_id, state_dbg);
    else n_pass++;
    clear_queues();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n_writes;
    repeat (20) @(negedge clk);
    n_total++;
    if (n_writes != base) $display("FAIL midreset_no_write: writes=%0d required 0", n_writes - base);
    else n_pass++;
    push_byte(1, 8'h91, 1'b1);
    expect_write(1, 8'h91);
    wait_quiet(ok);
    n_total++;
    if (!ok) $display("FAIL midreset_new_packet: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    int n_idle;
    clear_queues();
    push_byte(1, 8'hB0, 1'b1);
    push_byte(1, 8'hB1, 1'b0); push_byte(1, 8'hB2, 1'b1);
    expect_write(1, 8'hB0); expect_write(1, 8'hB1); expect_write(1, 8'hB2);
    base = n_writes;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (n_writes >= base + 1) break;
    end
    n_idle = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (n_writes >= base + 2) break;
      if (!bus.active) n_idle++;
    end
    n_total++;
    if (n_idle != 1) $display("FAIL back_to_back_idle: idle_cycles=%0d required 1", n_idle);
    else n_pass++;
    wait_quiet(ok);
    n_total++;
    if (!ok) $display("FAIL back_to_back_done: pending=%0d required 0 within budget", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_wrap();
    test_single();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 1024: idle cycles mid-packet before the grant is revoked.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  N_REQ x 8  per-requester byte.
REQ-007 SHALL have port req_last  input  N_REQ  byte is the final byte of its packet.
REQ-008 SHALL have port req_ready  output  N_REQ  byte accepted this cycle (valid && ready).
REQ-009 SHALL have port uart_busy  input  1  busy from the shared uart_tx.
REQ-010 SHALL have port uart_write  output  1  one-cycle write strobe to uart_tx.
REQ-011 SHALL have port uart_data  output  8  byte to uart_tx, valid while uart_write=1.
REQ-012 SHALL have port grant_id  output  clog2(N_REQ)  index of the current owner.
REQ-013 SHALL have port active  output  1  a packet grant is held.

Function
REQ-014 SHALL implement the FSM IDLE, SEND, WAIT_START, WAIT_DONE.
REQ-015 In IDLE with any req_valid, SHALL pick the winner round-robin, searching from rr_ptr upward with wrap; latch grant_id; go to SEND next cycle.
REQ-016 In SEND, when req_valid[grant_id]=1 and uart_busy=0, SHALL assert uart_write and req_ready[grant_id] in the same cycle, drive uart_data from req_data[grant_id], and go to WAIT_START.
REQ-017 SHALL assert at most one req_ready bit per cycle, only in SEND, only for grant_id.
REQ-018 In WAIT_START, SHALL stay for exactly one cycle (uart_tx raises busy one cycle after write), then go to WAIT_DONE.
REQ-019 In WAIT_DONE, on uart_busy=0: if the accepted byte had req_last=1, SHALL set rr_ptr to grant_id+1 (mod N_REQ) and go to IDLE; otherwise SHALL go to SEND.
REQ-020 SHALL never assert uart_write in two consecutive cycles, nor while uart_busy=1.
REQ-021 SHALL hold the grant across the whole packet; other requesters' valids SHALL be ignored until release.
REQ-022 In SEND with req_valid[grant_id]=0 for HOLD_TIMEOUT consecutive cycles, SHALL release the grant, advance rr_ptr as in REQ-019, and go to IDLE.
REQ-023 The timeout counter SHALL clear on every accepted byte and on entry to SEND.
REQ-024 active SHALL be 1 in SEND, WAIT_START and WAIT_DONE, and 0 in IDLE.
REQ-025 A single requester asserting continuously SHALL be re-granted after each packet; the cost is one IDLE cycle.

Reset
REQ-026 On rst, SHALL be asynchronous: state=IDLE, rr_ptr=0, grant_id=0, timeout counter=0.
REQ-027 During and after rst: uart_write=0, uart_data=0, req_ready=0, active=0.
REQ-028 Reset mid-packet SHALL drop the packet with no further write; the caller is responsible for resetting uart_tx alongside.

Structure
REQ-029 The state enum and clog2 width helpers SHALL live in package uart_pkg, shared with uart_tx.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, pointer; outputs: index, any).
REQ-031 uart_tx SHALL NOT be instantiated inside uart_tx_arbiter; the two SHALL be connected at the parent level.

Verification
REQ-032 Single requester: req 1 sends packet 0x41,0x42(last) -> two uart_write pulses, data 0x41 then 0x42, each issued only after busy falls; back to IDLE; rr_ptr=2.
REQ-033 Contention: req 0 and req 2 both valid at the same time, rr_ptr=0 -> req 0's full 3-byte packet completes with no interleaving, then req 2 is granted.
REQ-034 Wrap: rr_ptr=3, reqs 0 and 3 valid -> req 3 is granted first, then req 0.
REQ-035 Stall and timeout: HOLD_TIMEOUT=8, req 1 sends a non-last byte then drops valid -> released after 8 SEND cycles, active=0, and pending req 2 is granted.
REQ-036 Reset: rst asserted in WAIT_DONE mid-packet -> outputs go to zero without waiting for a clock edge, and there is no write after rst is released until a new req_valid.
REQ-037 Throughout all scenarios, an assertion SHALL check: uart_write implies !uart_busy && !$past(uart_write).
